repeat_event_delay_queue: RTL and testbench
===========================================

Name: repeat_event_delay_queue

Overview:
- Synthesizable producer stage for the intra-assignment timing-control tests.
- Captures a data sample on a handshake and holds it in an in-order queue.
- Releases the sample only after a per-request number of rising `clk` edges has elapsed, which is the RTL equivalent of `a = repeat (n) @(posedge clk) b`.
- Its output feeds the downstream assignment checker, which compares released values against the procedural (temp / `@(posedge clk)`) model.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 4: number of in-flight entries (≥2, power of two).
- DLY_W, 4: width of the per-request edge count; the maximum delay is 2^DLY_W−1.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: synchronous active-high reset.
- cap_valid, input, 1: capture request.
- cap_ready, output, 1: queue can accept; equals !full.
- cap_data, input, WIDTH: sample taken at the accepting edge.
- cap_delay, input, DLY_W: edge count n; a value of 0 is treated as 1.
- out_valid, output, 1: head entry is due.
- out_ready, input, 1: consumer accepts the head.
- out_data, output, WIDTH: head data.
- out_late, output, 1: head became due at an earlier edge and was not released then.
- occupancy, output, clog2(DEPTH+1): entries currently held.

Behaviour:
- Reset
  - On rst sampled high: all entries are flushed, head and tail pointers are set to 0, and occupancy = 0.
  - Outputs after reset: out_valid=0, out_late=0, out_data=0, cap_ready=1.
  - Reset mid-operation discards pending entries without releasing them.
- Capture
  - A capture is accepted when cap_valid && cap_ready at edge E.
  - The entry stores cap_data and cnt = max(cap_delay, 1), with overdue=0.
- Countdown
  - At every later edge, each occupied entry's cnt decrements, saturating at 0.
  - The countdown happens independently of backpressure.
- Release
  - out_valid = occupied(head) && head.cnt == 0. This is combinational from registers.
  - Earliest out_valid is therefore in the cycle after edge E+n, i.e. after exactly n posedges following the capture.
  - A pop occurs when out_valid && out_ready at an edge.
- Ordering
  - Release is strictly FIFO.
  - A younger entry that reaches cnt=0 while the head is not due waits (head-of-line). It accumulates overdue instead.
- Overdue tracking
  - At any edge where an entry has cnt==0 and is not popped, its overdue bit is set.
  - out_late = head.overdue. It is 0 when the entry is released in its earliest possible cycle.
- Full / empty
  - cap_ready = (occupancy != DEPTH).
  - When full, no pass-through: a capture and a pop in the same edge while full still rejects the capture.
  - When not full, a simultaneous capture and pop leaves occupancy unchanged.
  - When empty: out_valid=0 and out_data holds its last value (0 after reset).
- Wrap-around
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked separately so that full and empty are distinguishable.
- Latency: capture to earliest out_valid is n cycles; capture to out_valid is never less than n.

Decomposition:
- Shared package/include holds:
  - defaults for WIDTH, DEPTH and DLY_W;
  - the entry field layout (data, cnt, overdue, occupied);
  - the localparam PTR_W = clog2(DEPTH).
- One sub-module, delay_slot: one entry's cnt/overdue register with load, decrement and clear.
  - It is instantiated DEPTH times.
  - The pointer, occupancy and handshake logic stay in the top level.

Test Plan:
1. Reset, capture 0xA5 with n=3, out_ready=1 → out_valid first high in the cycle after the 3rd following posedge, out_data=0xA5, out_late=0, occupancy returns to 0.
2. Capture with n=0 → behaves exactly like n=1 (out_valid one cycle after the capture edge).
3. Capture 0x11 (n=5), then next cycle 0x22 (n=1), out_ready=1 → 0x22 waits behind 0x11; 0x11 releases with out_late=0, then 0x22 releases in the next cycle with out_late=1.
4. Fill DEPTH=4 entries with n=2 and out_ready=0 → cap_ready=0 at occupancy 4; a capture+pop edge while full rejects the capture; once out_ready=1, entries drain in order with out_late=1.
5. Assert rst for one cycle with 3 entries pending → out_valid=0, occupancy=0, cap_ready=1 next cycle; pending data never appears.
6. Stream 10 captures back-to-back (n=1..4) with random out_ready → output order equals capture order, no value is lost, and pointer wrap causes no corruption.

Source files
------------

// File: rtl/repeat_event_delay_queue_pkg.sv
// rtl/repeat_event_delay_queue_pkg.sv - shared defaults, entry layout and pointer sizing
package repeat_event_delay_queue_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int DLY_W_DEF = 4;

    localparam int PTR_W = $clog2(DEPTH_DEF);

    // Logical view of one queue entry; the top keeps data, the slot keeps the rest.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] data;
        logic [DLY_W_DEF-1:0] cnt;
        logic                 overdue;
        logic                 occupied;
    } entry_t;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/repeat_event_delay_queue_delay_slot.sv
// rtl/repeat_event_delay_queue_delay_slot.sv - one entry's occupancy, countdown and overdue state
module delay_slot
    import repeat_event_delay_queue_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DLY_W-1:0] i_delay,
    input  logic             i_pop,
    output logic             o_occupied,
    output logic [DLY_W-1:0] o_cnt,
    output logic             o_overdue
);

    logic             r_occupied;
    logic [DLY_W-1:0] r_cnt;
    logic             r_overdue;

    // A due entry that survives an edge without being popped is marked overdue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occupied <= 1'b0;
            r_cnt      <= '0;
            r_overdue  <= 1'b0;
        end else if (i_load) begin
            r_occupied <= 1'b1;
            r_cnt      <= (i_delay == '0) ? DLY_W'(1) : i_delay;
            r_overdue  <= 1'b0;
        end else if (i_pop) begin
            r_occupied <= 1'b0;
            r_cnt      <= '0;
            r_overdue  <= 1'b0;
        end else if (r_occupied) begin
            if (r_cnt == '0) begin
                r_overdue <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_occupied = r_occupied;
    assign o_cnt      = r_cnt;
    assign o_overdue  = r_overdue;

endmodule

// File: rtl/repeat_event_delay_queue.sv
// rtl/repeat_event_delay_queue.sv - in-order queue releasing each sample n clock edges after capture
module repeat_event_delay_queue
    import repeat_event_delay_queue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cap_valid,
    output logic                         cap_ready,
    input  logic [WIDTH-1:0]             cap_data,
    input  logic [DLY_W-1:0]             cap_delay,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_late,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW    = ptr_w(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [WIDTH-1:0] r_last;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_pop_sel;
    logic [DEPTH-1:0] w_slot_occ;
    logic [DEPTH-1:0] w_slot_late;
    logic [DLY_W-1:0] w_slot_cnt [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_head_due;

    assign cap_ready  = (r_occ != OCC_W'(DEPTH));
    assign w_head_due = w_slot_occ[r_head] && (w_slot_cnt[r_head] == '0);
    assign w_push     = cap_valid && cap_ready;
    assign w_pop      = w_head_due && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign w_load[i]    = w_push && (r_tail == PW'(i));
        assign w_pop_sel[i] = w_pop && (r_head == PW'(i));

        delay_slot #(
            .DLY_W (DLY_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load[i]),
            .i_delay    (cap_delay),
            .i_pop      (w_pop_sel[i]),
            .o_occupied (w_slot_occ[i]),
            .o_cnt      (w_slot_cnt[i]),
            .o_overdue  (w_slot_late[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_last <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_tail] <= cap_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_last <= r_data[r_head];
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Once the queue drains, the last released value stays on the output.
    assign out_valid = w_head_due;
    assign out_data  = w_slot_occ[r_head] ? r_data[r_head] : r_last;
    assign out_late  = w_slot_occ[r_head] && w_slot_late[r_head];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_repeat_event_delay_queue.sv
// tb/tb_repeat_event_delay_queue.sv - directed scoreboard bench for repeat_event_delay_queue
module tb_repeat_event_delay_queue;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_valid;
    logic          cap_ready;
    logic [W-1:0]  cap_data;
    logic [DW-1:0] cap_delay;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_late;
    logic [2:0]    occupancy;

    repeat_event_delay_queue #(.WIDTH(W), .DEPTH(D), .DLY_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .cap_delay (cap_delay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_late  (out_late),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
        bit           late;
    } ent_t;

    ent_t         sb[$];
    logic [W-1:0] m_last;
    int           n_vec;
    int           n_err;
    bit           last_push;
    int           n_rel;
    int           accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare current outputs against the model, then advance the model across the next edge.
    task automatic cyc();
        bit   due;
        bit   pop;
        bit   push;
        ent_t e;
        due = (sb.size() > 0) && (sb[0].cnt == 0);
        check("out_valid", 32'(out_valid), 32'(due));
        check("cap_ready", 32'(cap_ready), 32'(sb.size() != D));
        check("occupancy", 32'(occupancy), 32'(sb.size()));
        if (due) begin
            check("out_data", 32'(out_data), 32'(sb[0].data));
            check("out_late", 32'(out_late), 32'(sb[0].late));
        end else if (sb.size() == 0) begin
            check("out_data_hold", 32'(out_data), 32'(m_last));
        end
        if (out_valid && out_ready) n_rel++;
        push = 1'b0;
        if (rst) begin
            sb.delete();
            m_last = '0;
        end else begin
            pop  = due && out_ready;
            push = cap_valid && (sb.size() != D);
            for (int i = 0; i < sb.size(); i++) begin
                if (!(pop && i == 0)) begin
                    e = sb[i];
                    if (e.cnt == 0) e.late = 1'b1;
                    else e.cnt = e.cnt - 1;
                    sb[i] = e;
                end
            end
            if (pop) begin
                m_last = sb[0].data;
                void'(sb.pop_front());
            end
            if (push) begin
                e.data = cap_data;
                e.cnt  = (cap_delay == '0) ? 1 : int'(cap_delay);
                e.late = 1'b0;
                sb.push_back(e);
            end
        end
        last_push = push;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_rel = 0; accepted = 0;
        m_last = '0;
        rst = 1'b1; cap_valid = 1'b0; out_ready = 1'b0;
        cap_data = '0; cap_delay = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc();
        rst = 1'b0;

        // single capture, n=3
        out_ready = 1'b1;
        cap_valid = 1'b1; cap_data = 8'hA5; cap_delay = 4'd3;
        cyc();
        cap_valid = 1'b0;
        repeat (6) cyc();

        // n=0 behaves as n=1
        cap_valid = 1'b1; cap_data = 8'h3C; cap_delay = 4'd0;
        cyc();
        cap_valid = 1'b0;
        repeat (3) cyc();

        // head-of-line blocking: younger entry goes late
        cap_valid = 1'b1; cap_data = 8'h11; cap_delay = 4'd5;
        cyc();
        cap_data = 8'h22; cap_delay = 4'd1;
        cyc();
        cap_valid = 1'b0;
        repeat (8) cyc();

        // fill, full rejection incl. capture+pop while full, ordered late drain
        out_ready = 1'b0; cap_valid = 1'b1; cap_delay = 4'd2;
        for (int i = 0; i < D; i++) begin
            cap_data = 8'h40 + 8'(i);
            cyc();
        end
        cap_data = 8'h4F;
        repeat (4) cyc();
        out_ready = 1'b1;
        cyc();
        cap_valid = 1'b0;
        repeat (8) cyc();

        // reset with pending entries
        out_ready = 1'b0; cap_valid = 1'b1; cap_delay = 4'd1;
        for (int i = 0; i < 3; i++) begin
            cap_data = 8'h61 + 8'(i);
            cyc();
        end
        cap_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();

        // back-to-back stream with random backpressure across pointer wrap
        n_rel = 0;
        for (int k = 0; k < 100 && accepted < 10; k++) begin
            cap_valid = 1'b1;
            cap_data  = 8'h80 + 8'(accepted);
            cap_delay = DW'(1 + accepted % 4);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            if (last_push) accepted++;
        end
        cap_valid = 1'b0;
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        out_ready = 1'b1;
        repeat (2) cyc();
        check("stream_released", 32'(n_rel), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
